memory_writeback_stage: RTL and testbench
=========================================

Name: memory_writeback_stage

Overview:
- Pipeline stage directly downstream of the data-RAM address/write-enable generator.
- Captures each LD/ST/LDR/STR once its address is issued, and absorbs the data RAM's 1-cycle read latency.
- Produces register-file write-backs: port 0 carries load data, port 1 carries the pre/post increment/decrement base-register update.
- Handles stall, flush and same-register conflicts.

Parameters:
- DW, 16, data/register width
- RIDX, 3, register index width (R0-R7)
- STEP, 1, base increment/decrement amount (matches the address generator's +1/-1)

Ports:
- clk  in  1  system clock, rising edge
- reset_n  in  1  asynchronous active-low reset
- stall  in  1  freeze S1/S2 advancement
- flush  in  1  squash the instruction in S1
- req_valid  in  1  memory instruction issued to RAM this cycle
- req_load  in  1  instruction is LD/LDR
- req_byte  in  1  byte access (.B)
- req_inc  in  1  increment requested
- req_dec  in  1  decrement requested
- req_dst  in  RIDX  load destination register
- req_base  in  RIDX  base (address) register index
- req_base_val  in  DW  base register value used for the address
- req_dst_old  in  DW  current destination value, for byte merge
- ram_rdata  in  DW  RAM read data, valid the cycle after the address
- wb0_en  out  1  load write-back strobe
- wb0_idx  out  RIDX  load destination index
- wb0_data  out  DW  load result
- wb1_en  out  1  base-update strobe
- wb1_idx  out  RIDX  base register index
- wb1_data  out  DW  updated base value
- s1_busy  out  1  S1 holds a valid load (for the hazard unit)
- s1_dst  out  RIDX  S1 load destination

Behaviour:
- Reset (async, reset_n=0): S1/S2 valid flags, hold flag and all outputs clear to 0. This holds mid-operation; in-flight instructions are discarded.
- Pipeline, no stall:
  - Cycle t: req_valid=1 latches the request into S1.
  - Cycle t+1: S1 valid; ram_rdata is sampled; S2 registers load first.
  - Cycle t+2: wb0/wb1 outputs driven from S2.
  - Throughput one instruction per cycle.
- Accept rule: S1 loads only when stall=0. req_valid=0 with stall=0 clears S1 valid.
- Stall=1:
  - S1 holds.
  - If S1 holds a load on the first stall cycle, ram_rdata is captured into a hold register and the hold flag is set.
  - S2 computation uses the hold register while the flag is set. The flag clears when S1 advances.
  - S2 does not reload.
- Write-back strobes pulse exactly one cycle per instruction, in the cycle after S2 loads. Stall does not repeat them.
- flush=1 clears S1 valid and the hold flag in the same edge. flush has priority over stall and over req_valid. S2 (committed) is unaffected.
- Load data:
  - Word: wb0_data = rdata.
  - Byte: wb0_data = {dst_old[15:8], rdata[7:0]}.
  - wb0_en = load.
- Base update:
  - If inc: wb1_data = base_val + STEP. If dec: wb1_data = base_val - STEP. Modulo 2^DW, with wrap (0xFFFF+1 = 0x0000; 0x0000-1 = 0xFFFF).
  - Pre- vs post-modify does not change the written value.
  - inc and dec both set: inc wins.
  - wb1_en = inc|dec.
- Conflict: on a load with req_dst == req_base and inc|dec, wb0 wins and wb1_en is forced to 0.
- Stores: wb0_en=0 always; only the base update may write.
- s1_busy = S1 valid & load. s1_dst mirrors S1 dst and is 0 when not busy.

Test Plan:
- LD word, R2=0x1000, rdata=0xBEEF at t+1, dst R3 → t+2: wb0_en=1, idx 3, data 0xBEEF; wb1_en=0.
- LD.B with post-inc, base R1=0xFFFF, dst R4 old 0x12AB, rdata=0x0077 → wb0_data 0x1277; wb1 R1=0x0000; both strobes exactly 1 cycle.
- ST with pre-dec, base R5=0x0000 → wb0_en=0, wb1 idx 5 data 0xFFFF.
- LD issued, stall high 3 cycles from t+1, rdata changes to 0xDEAD after t+1 (was 0x5A5A) → single wb0 pulse with 0x5A5A after stall drops.
- LD dst=base=R2 with inc, rdata 0x0042 → wb0 R2=0x0042, wb1_en stays 0.
- Back-to-back loads; flush at t+1 on the first → only the second writes back. Reset_n low mid-stream → all strobes 0 immediately, no write after release.

Source files
------------

// File: rtl/memory_writeback_stage.sv
// memory_writeback_stage
//   Two-stage pipeline stage that sits behind the data-RAM address generator.
//   S1 captures a LD/ST/LDR/STR in the cycle its address is issued. S2 combines
//   the RAM read data, which arrives one cycle later, with the captured request.
//   S2 drives two register-file write-back ports:
//     port 0 carries load data (word, or byte merged into the old destination),
//     port 1 carries the incremented/decremented base register.
//
// Ports
//   clk, reset_n        : rising-edge clock, asynchronous active-low reset
//   stall               : freeze S1/S2 advancement
//   flush               : squash the instruction held in S1
//   req_*               : request issued to the RAM this cycle
//   ram_rdata           : RAM read data, valid the cycle after the address
//   wb0_en/idx/data     : load write-back, one-cycle strobe
//   wb1_en/idx/data     : base-update write-back, one-cycle strobe
//   s1_busy, s1_dst     : S1 holds a load, and its destination (for hazards)

module memory_writeback_stage #(
  parameter int DW   = 16,
  parameter int RIDX = 3,
  parameter int STEP = 1
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            stall,
  input  logic            flush,
  input  logic            req_valid,
  input  logic            req_load,
  input  logic            req_byte,
  input  logic            req_inc,
  input  logic            req_dec,
  input  logic [RIDX-1:0] req_dst,
  input  logic [RIDX-1:0] req_base,
  input  logic [DW-1:0]   req_base_val,
  input  logic [DW-1:0]   req_dst_old,
  input  logic [DW-1:0]   ram_rdata,
  output logic            wb0_en,
  output logic [RIDX-1:0] wb0_idx,
  output logic [DW-1:0]   wb0_data,
  output logic            wb1_en,
  output logic [RIDX-1:0] wb1_idx,
  output logic [DW-1:0]   wb1_data,
  output logic            s1_busy,
  output logic [RIDX-1:0] s1_dst
);

  // S1 state
  logic            s1_valid_q;
  logic            s1_load_q;
  logic            s1_byte_q;
  logic            s1_inc_q;
  logic            s1_dec_q;
  logic [RIDX-1:0] s1_dst_q;
  logic [RIDX-1:0] s1_base_q;
  logic [DW-1:0]   s1_base_val_q;
  logic [DW-1:0]   s1_dst_old_q;

  // Read data saved when S1 is stalled, since ram_rdata is only valid for one cycle
  logic            hold_flag_q;
  logic [DW-1:0]   hold_data_q;

  logic            advance;
  logic            conflict;
  logic [DW-1:0]   rd_sel;
  logic [DW-1:0]   ld_result;
  logic [DW-1:0]   base_next;
  logic            unused_dst_old_lo;

  // S1 moves into S2 only when it holds something and is neither frozen nor squashed
  assign advance = s1_valid_q & ~stall & ~flush;

  // The low byte of the old destination is always overwritten by a byte load
  assign unused_dst_old_lo = ^s1_dst_old_q[7:0];

  always_comb begin
    rd_sel    = hold_flag_q ? hold_data_q : ram_rdata;
    ld_result = s1_byte_q ? {s1_dst_old_q[DW-1:8], rd_sel[7:0]} : rd_sel;
    // inc has priority when both inc and dec are set; arithmetic wraps modulo 2^DW
    base_next = s1_inc_q ? (s1_base_val_q + DW'(STEP)) : (s1_base_val_q - DW'(STEP));
    // A load whose destination is also its base register: the load result wins
    conflict  = s1_load_q & (s1_dst_q == s1_base_q);
  end

  // S1 register: flush beats stall, stall beats a new request
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid_q    <= 1'b0;
      s1_load_q     <= 1'b0;
      s1_byte_q     <= 1'b0;
      s1_inc_q      <= 1'b0;
      s1_dec_q      <= 1'b0;
      s1_dst_q      <= '0;
      s1_base_q     <= '0;
      s1_base_val_q <= '0;
      s1_dst_old_q  <= '0;
    end else if (flush) begin
      s1_valid_q <= 1'b0;
    end else if (!stall) begin
      s1_valid_q    <= req_valid;
      s1_load_q     <= req_load;
      s1_byte_q     <= req_byte;
      s1_inc_q      <= req_inc;
      s1_dec_q      <= req_dec;
      s1_dst_q      <= req_dst;
      s1_base_q     <= req_base;
      s1_base_val_q <= req_base_val;
      s1_dst_old_q  <= req_dst_old;
    end
  end

  // Hold register: only the first stall cycle sees the real read data, so capture
  // it once and keep it until S1 advances or is flushed.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hold_flag_q <= 1'b0;
      hold_data_q <= '0;
    end else if (flush || !stall) begin
      hold_flag_q <= 1'b0;
    end else if (s1_valid_q && s1_load_q && !hold_flag_q) begin
      hold_flag_q <= 1'b1;
      hold_data_q <= ram_rdata;
    end
  end

  // S2 doubles as the write-back output register. Strobes are recomputed every
  // cycle, so they pulse once per instruction and drop during stalls.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wb0_en   <= 1'b0;
      wb0_idx  <= '0;
      wb0_data <= '0;
      wb1_en   <= 1'b0;
      wb1_idx  <= '0;
      wb1_data <= '0;
    end else begin
      wb0_en <= advance & s1_load_q;
      wb1_en <= advance & (s1_inc_q | s1_dec_q) & ~conflict;
      if (advance) begin
        wb0_idx  <= s1_dst_q;
        wb0_data <= ld_result;
        wb1_idx  <= s1_base_q;
        wb1_data <= base_next;
      end
    end
  end

  assign s1_busy = s1_valid_q & s1_load_q;
  assign s1_dst  = s1_busy ? s1_dst_q : '0;

endmodule

// File: tb/tb_memory_writeback_stage.sv
module tb_memory_writeback_stage;

  logic        clk;
  logic        reset_n;
  logic        stall;
  logic        flush;
  logic        req_valid;
  logic        req_load;
  logic        req_byte;
  logic        req_inc;
  logic        req_dec;
  logic [2:0]  req_dst;
  logic [2:0]  req_base;
  logic [15:0] req_base_val;
  logic [15:0] req_dst_old;
  logic [15:0] ram_rdata;
  logic        wb0_en;
  logic [2:0]  wb0_idx;
  logic [15:0] wb0_data;
  logic        wb1_en;
  logic [2:0]  wb1_idx;
  logic [15:0] wb1_data;
  logic        s1_busy;
  logic [2:0]  s1_dst;

  typedef struct {
    logic        wb0_en;
    logic [2:0]  wb0_idx;
    logic [15:0] wb0_data;
    logic        wb1_en;
    logic [2:0]  wb1_idx;
    logic [15:0] wb1_data;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  memory_writeback_stage #(.DW(16), .RIDX(3), .STEP(1)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .stall        (stall),
    .flush        (flush),
    .req_valid    (req_valid),
    .req_load     (req_load),
    .req_byte     (req_byte),
    .req_inc      (req_inc),
    .req_dec      (req_dec),
    .req_dst      (req_dst),
    .req_base     (req_base),
    .req_base_val (req_base_val),
    .req_dst_old  (req_dst_old),
    .ram_rdata    (ram_rdata),
    .wb0_en       (wb0_en),
    .wb0_idx      (wb0_idx),
    .wb0_data     (wb0_data),
    .wb1_en       (wb1_en),
    .wb1_idx      (wb1_idx),
    .wb1_data     (wb1_data),
    .s1_busy      (s1_busy),
    .s1_dst       (s1_dst)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_stimulus(input logic load, input logic byte_acc, input logic inc,
                                input logic dec, input logic [2:0] dst, input logic [2:0] base,
                                input logic [15:0] base_val, input logic [15:0] dst_old);
    req_valid    = 1'b1;
    req_load     = load;
    req_byte     = byte_acc;
    req_inc      = inc;
    req_dec      = dec;
    req_dst      = dst;
    req_base     = base;
    req_base_val = base_val;
    req_dst_old  = dst_old;
  endtask

  task automatic idle_request();
    req_valid    = 1'b0;
    req_load     = 1'b0;
    req_byte     = 1'b0;
    req_inc      = 1'b0;
    req_dec      = 1'b0;
    req_dst      = 3'd0;
    req_base     = 3'd0;
    req_base_val = 16'h0000;
    req_dst_old  = 16'h0000;
  endtask

  task automatic push_exp(input logic e0, input logic [2:0] i0, input logic [15:0] d0,
                          input logic e1, input logic [2:0] i1, input logic [15:0] d1);
    exp_t e;
    e.wb0_en = e0; e.wb0_idx = i0; e.wb0_data = d0;
    e.wb1_en = e1; e.wb1_idx = i1; e.wb1_data = d1;
    sb.push_back(e);
  endtask

  // Scoreboard monitor: every write-back strobe cycle consumes one expectation
  always @(negedge clk) begin
    if (wb0_en === 1'b1 || wb1_en === 1'b1) begin
      if (sb.size() == 0) begin
        check_output("unexpected_wb", {30'd0, wb1_en, wb0_en}, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check_output("wb0_en", wb0_en, e.wb0_en);
        if (e.wb0_en) begin
          check_output("wb0_idx", wb0_idx, e.wb0_idx);
          check_output("wb0_data", wb0_data, e.wb0_data);
        end
        check_output("wb1_en", wb1_en, e.wb1_en);
        if (e.wb1_en) begin
          check_output("wb1_idx", wb1_idx, e.wb1_idx);
          check_output("wb1_data", wb1_data, e.wb1_data);
        end
      end
    end
  end

  initial begin
    reset_n   = 1'b0;
    stall     = 1'b0;
    flush     = 1'b0;
    ram_rdata = 16'h0000;
    idle_request();
    #1;
    check_output("rst_wb0_en", wb0_en, 1'b0);
    check_output("rst_wb1_en", wb1_en, 1'b0);
    check_output("rst_s1_busy", s1_busy, 1'b0);
    check_output("rst_s1_dst", s1_dst, 3'd0);
    check_output("rst_wb0_data", wb0_data, 16'h0000);
    tick();
    tick();
    reset_n = 1'b1;
    tick();

    // LD word, base R2=0x1000, dst R3
    apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0, 3'd3, 3'd2, 16'h1000, 16'h0000);
    tick();
    idle_request();
    ram_rdata = 16'hBEEF;
    push_exp(1'b1, 3'd3, 16'hBEEF, 1'b0, 3'd0, 16'h0000);
    check_output("ld_s1_busy", s1_busy, 1'b1);
    check_output("ld_s1_dst", s1_dst, 3'd3);
    tick();
    ram_rdata = 16'h0000;
    tick();
    tick();

    // LD.B post-inc with base wrap, followed back-to-back by ST pre-dec with wrap
    apply_stimulus(1'b1, 1'b1, 1'b1, 1'b0, 3'd4, 3'd1, 16'hFFFF, 16'h12AB);
    tick();
    apply_stimulus(1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 3'd5, 16'h0000, 16'h0000);
    ram_rdata = 16'h0077;
    push_exp(1'b1, 3'd4, 16'h1277, 1'b1, 3'd1, 16'h0000);
    check_output("ldb_s1_dst", s1_dst, 3'd4);
    tick();
    idle_request();
    ram_rdata = 16'h0000;
    push_exp(1'b0, 3'd0, 16'h0000, 1'b1, 3'd5, 16'hFFFF);
    check_output("st_s1_busy", s1_busy, 1'b0);
    check_output("st_s1_dst", s1_dst, 3'd0);
    tick();
    tick();
    tick();

    // LD stalled for 3 cycles; read data changes while stalled
    apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0, 3'd6, 3'd0, 16'h2000, 16'h0000);
    tick();
    idle_request();
    ram_rdata = 16'h5A5A;
    stall     = 1'b1;
    push_exp(1'b1, 3'd6, 16'h5A5A, 1'b0, 3'd0, 16'h0000);
    tick();
    ram_rdata = 16'hDEAD;
    check_output("stall_s1_busy", s1_busy, 1'b1);
    check_output("stall_wb0_en", wb0_en, 1'b0);
    tick();
    tick();
    stall = 1'b0;
    tick();
    tick();
    tick();

    // LD with dst == base and inc: load wins, base update suppressed
    apply_stimulus(1'b1, 1'b0, 1'b1, 1'b0, 3'd2, 3'd2, 16'h0010, 16'h0000);
    tick();
    idle_request();
    ram_rdata = 16'h0042;
    push_exp(1'b1, 3'd2, 16'h0042, 1'b0, 3'd0, 16'h0000);
    tick();
    tick();
    tick();

    // Flush squashes the first load in S1; flush outranks req_valid, so the
    // second load issues in the cycle after the flush
    apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0, 3'd3, 3'd0, 16'h3000, 16'h0000);
    tick();
    idle_request();
    flush     = 1'b1;
    ram_rdata = 16'h1111;
    tick();
    flush = 1'b0;
    check_output("flush_s1_busy", s1_busy, 1'b0);
    apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0, 3'd4, 3'd0, 16'h3001, 16'h0000);
    tick();
    idle_request();
    ram_rdata = 16'h3333;
    push_exp(1'b1, 3'd4, 16'h3333, 1'b0, 3'd0, 16'h0000);
    tick();
    tick();
    tick();

    // Reset mid-stream: load A writes back, load B is in S1 when reset hits
    apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0, 3'd5, 3'd0, 16'h4000, 16'h0000);
    tick();
    apply_stimulus(1'b1, 1'b0, 1'b1, 1'b0, 3'd6, 3'd7, 16'h4001, 16'h0000);
    ram_rdata = 16'hAAAA;
    push_exp(1'b1, 3'd5, 16'hAAAA, 1'b0, 3'd0, 16'h0000);
    tick();
    idle_request();
    ram_rdata = 16'hBBBB;
    @(negedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    check_output("midrst_wb0_en", wb0_en, 1'b0);
    check_output("midrst_wb1_en", wb1_en, 1'b0);
    check_output("midrst_s1_busy", s1_busy, 1'b0);
    tick();
    tick();
    reset_n = 1'b1;
    tick();
    tick();
    tick();
    tick();
    check_output("post_rst_wb0_en", wb0_en, 1'b0);
    check_output("sb_drained", sb.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
